// File: rtl/dds_cfg_sequencer.sv
`timescale 1ns/1ps
// dds_cfg_sequencer: UART-framed configuration front end for a 4-channel DDS.
// A frame AA CMD DH DL CHK writes a shadow phase offset or the shadow channel
// mask. CMD 0x20 copies the whole shadow set to the live outputs on the next
// channel-0 phase wrap (sync_pulse), so all channels change phase together.
// Every frame that reaches EXEC is answered with one ACK (0x06) or NAK (0x15).
module dds_cfg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  input  logic       sync_pulse,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [9:0] phase_1,
  output logic [9:0] phase_2,
  output logic [9:0] phase_3,
  output logic [9:0] phase_4,
  output logic [3:0] chan_en,
  output logic       cfg_pending
);

  // The counter only has to reach TIMEOUT_CYC-1 before the timeout fires.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;
  localparam logic [7:0] CMD_MASK  = 8'h10;
  localparam logic [7:0] CMD_APPLY = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DH, S_DL, S_CHK, S_EXEC, S_WAIT_SYNC, S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, dh_q, dl_q, chk_q;
  logic [7:0]       resp_q;
  logic [9:0]       sh_ph_q [4];
  logic [9:0]       ph_q    [4];
  logic [3:0]       sh_mask_q, mask_q;
  logic             pending_q;
  logic             rx_en_q;

  logic       chk_ok, timeout, is_apply;
  logic       wr_phase, wr_mask, commit, resp_ld;
  logic [7:0] resp_val;

  assign chk_ok   = ((cmd_q ^ dh_q ^ dl_q) == chk_q);
  assign timeout  = (cnt_q == CNT_LAST);
  assign is_apply = chk_ok && (cmd_q == CMD_APPLY);

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the shared inter-byte / sync-wait timeout counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (rx_done && rx_data == SYNC_BYTE) state_d = S_CMD;
      S_CMD:       if (rx_done) state_d = S_DH;   else if (timeout) state_d = S_IDLE;
      S_DH:        if (rx_done) state_d = S_DL;   else if (timeout) state_d = S_IDLE;
      S_DL:        if (rx_done) state_d = S_CHK;  else if (timeout) state_d = S_IDLE;
      S_CHK:       if (rx_done) state_d = S_EXEC; else if (timeout) state_d = S_IDLE;
      S_EXEC:      state_d = is_apply ? S_WAIT_SYNC : S_RESP;
      S_WAIT_SYNC: if (sync_pulse || timeout) state_d = S_RESP;
      S_RESP:      if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    // Any state change (including each accepted byte) restarts the count.
    cnt_d = '0;
    if ((state_q inside {S_CMD, S_DH, S_DL, S_CHK, S_WAIT_SYNC}) && (state_d == state_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Output decode: transmit strobe, register write enables and response byte.
  always_comb begin
    tx_start = 1'b0;
    wr_phase = 1'b0;
    wr_mask  = 1'b0;
    commit   = 1'b0;
    resp_ld  = 1'b0;
    resp_val = NAK_BYTE;
    unique case (state_q)
      S_EXEC: begin
        wr_phase = chk_ok && (cmd_q >= 8'h01) && (cmd_q <= 8'h04);
        wr_mask  = chk_ok && (cmd_q == CMD_MASK);
        resp_ld  = !is_apply;
        resp_val = (wr_phase || wr_mask) ? ACK_BYTE : NAK_BYTE;
      end
      S_WAIT_SYNC: begin
        commit   = sync_pulse || timeout;
        resp_ld  = commit;
        resp_val = sync_pulse ? ACK_BYTE : NAK_BYTE;
      end
      S_RESP:  tx_start = !tx_busy;
      default: ;
    endcase
  end

  // Counter, received-byte latches, response byte and registered rx_en.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q   <= '0;
      cmd_q   <= '0;
      dh_q    <= '0;
      dl_q    <= '0;
      chk_q   <= '0;
      resp_q  <= '0;
      rx_en_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (rx_done) begin
        if (state_q == S_CMD) cmd_q <= rx_data;
        if (state_q == S_DH)  dh_q  <= rx_data;
        if (state_q == S_DL)  dl_q  <= rx_data;
        if (state_q == S_CHK) chk_q <= rx_data;
      end
      if (resp_ld) resp_q <= resp_val;
      // Registered so rx_en rises on the first edge after reset release.
      rx_en_q <= !(state_d inside {S_EXEC, S_WAIT_SYNC, S_RESP});
    end
  end

  // Shadow configuration and the live set it is committed into.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 4; i++) begin
        sh_ph_q[i] <= '0;
        ph_q[i]    <= '0;
      end
      sh_mask_q <= 4'hF;
      mask_q    <= 4'hF;
      pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_phase && cmd_q[2:0] == 3'(i + 1)) sh_ph_q[i] <= {dh_q[1:0], dl_q};
        if (commit) ph_q[i] <= sh_ph_q[i];
      end
      if (wr_mask) sh_mask_q <= dl_q[3:0];
      if (commit)  mask_q    <= sh_mask_q;
      if (commit)                   pending_q <= 1'b0;
      else if (wr_phase || wr_mask) pending_q <= 1'b1;
    end
  end

  assign rx_en       = rx_en_q;
  assign tx_data     = resp_q;
  assign phase_1     = ph_q[0];
  assign phase_2     = ph_q[1];
  assign phase_3     = ph_q[2];
  assign phase_4     = ph_q[3];
  assign chan_en     = mask_q;
  assign cfg_pending = pending_q;

endmodule

// File: tb/tb_dds_cfg_sequencer.sv
`timescale 1ns/1ps
// Testbench for dds_cfg_sequencer: frames are driven byte by byte, the expected
// response byte is queued when a frame is sent, and every tx_start pops and
// compares one entry. A small model tracks shadow and live configuration.
module tb_dds_cfg_sequencer;

  localparam int unsigned T = 300;

  logic       CLK = 1'b0;
  logic       RSTn, rx_done, sync_pulse, tx_busy;
  logic [7:0] rx_data;
  logic       rx_en, tx_start, cfg_pending;
  logic [7:0] tx_data;
  logic [9:0] phase_1, phase_2, phase_3, phase_4;
  logic [3:0] chan_en;

  int errors = 0, checks = 0, cyc = 0, tx_count = 0;
  int last_start_cyc = -1, last_rx_cyc = -1;
  logic [7:0] sb [$];

  logic [9:0] m_sh_ph [4];
  logic [9:0] m_ph    [4];
  logic [3:0] m_sh_mask, m_mask;
  logic       m_pending;

  dds_cfg_sequencer #(.TIMEOUT_CYC(T)) dut (
    .CLK(CLK), .RSTn(RSTn), .rx_done(rx_done), .rx_data(rx_data), .rx_en(rx_en),
    .sync_pulse(sync_pulse), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .phase_1(phase_1), .phase_2(phase_2), .phase_3(phase_3), .phase_4(phase_4),
    .chan_en(chan_en), .cfg_pending(cfg_pending)
  );

  always #5 CLK = ~CLK;

  // One clock: observe on the falling edge, return just after the rising edge.
  task automatic tick();
    logic [7:0] exp;
    @(negedge CLK);
    if (rx_done) last_rx_cyc = cyc;
    if (tx_start === 1'b1) begin
      tx_count++;
      last_start_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start: tx_data=%02h, no response expected", tx_data);
      end else begin
        exp = sb.pop_front();
        if (tx_data !== exp) begin
          errors++;
          $display("FAIL resp_byte: got %02h expected %02h", tx_data, exp);
        end
      end
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh_ph[i] = '0;
      m_ph[i]    = '0;
    end
    m_sh_mask = 4'hF;
    m_mask    = 4'hF;
    m_pending = 1'b0;
  endtask

  task automatic model_commit();
    for (int i = 0; i < 4; i++) m_ph[i] = m_sh_ph[i];
    m_mask    = m_sh_mask;
    m_pending = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Sends a full frame; for everything except apply the response is queued here.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] chk);
    if (chk != (cmd ^ dh ^ dl)) sb.push_back(8'h15);
    else if (cmd >= 8'h01 && cmd <= 8'h04) begin
      m_sh_ph[cmd - 8'h01] = {dh[1:0], dl};
      m_pending = 1'b1;
      sb.push_back(8'h06);
    end else if (cmd == 8'h10) begin
      m_sh_mask = dl[3:0];
      m_pending = 1'b1;
      sb.push_back(8'h06);
    end else if (cmd != 8'h20) sb.push_back(8'h15);
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(dh);
    send_byte(dl);
    send_byte(chk);
  endtask

  // Apply frame followed by a sync pulse `delay` cycles later; ACK queued.
  task automatic apply_with_sync(input int delay);
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    repeat (delay) tick();
    sb.push_back(8'h06);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    model_commit();
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout: %0d response(s) outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_start, tx_data, rx_en}
        !== {40'h0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: ph=%h/%h/%h/%h en=%h pend=%b txs=%b txd=%h rxen=%b",
               phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_start, tx_data, rx_en);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (rx_en !== 1'b0) begin
      errors++;
      $display("FAIL rx_en_before_edge: got %b required 0", rx_en);
    end
    @(posedge CLK);
    #1;
    cyc++;
    checks++;
    if (rx_en !== 1'b1) begin
      errors++;
      $display("FAIL rx_en_after_edge: got %b required 1", rx_en);
    end
  endtask

  task automatic test_phase_write();
    send_frame(8'h02, 8'h01, 8'h2C, 8'h2F);
    wait_resp(10);
    checks++;
    if (last_start_cyc - last_rx_cyc != 2) begin
      errors++;
      $display("FAIL ack_latency: got %0d cycles required 2", last_start_cyc - last_rx_cyc);
    end
    checks++;
    if ({phase_2, cfg_pending} !== {10'h000, 1'b1}) begin
      errors++;
      $display("FAIL shadow_only: phase_2=%h pend=%b required 000/1", phase_2, cfg_pending);
    end
  endtask

  task automatic test_commit();
    int tx0 = tx_count;
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    repeat (10) tick();
    checks++;
    if ({tx_count == tx0, rx_en, phase_2} !== {1'b1, 1'b0, 10'h000}) begin
      errors++;
      $display("FAIL wait_sync_hold: tx=%0d rx_en=%b phase_2=%h required %0d/0/000",
               tx_count, rx_en, phase_2, tx0);
    end
    sb.push_back(8'h06);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    model_commit();
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending}
        !== {m_ph[0], m_ph[1], m_ph[2], m_ph[3], m_mask, m_pending}) begin
      errors++;
      $display("FAIL commit_live: ph=%h/%h/%h/%h en=%h pend=%b required phase_2=%h",
               phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, m_ph[1]);
    end
    wait_resp(10);
  endtask

  task automatic test_nak();
    send_frame(8'h03, 8'h00, 8'h05, 8'h07);
    wait_resp(10);
    checks++;
    if (cfg_pending !== m_pending) begin
      errors++;
      $display("FAIL bad_chk_pending: got %b required %b", cfg_pending, m_pending);
    end
    send_frame(8'h30, 8'h00, 8'h00, 8'h30);
    wait_resp(10);
  endtask

  task automatic test_timeout();
    int tx0 = tx_count;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (T + 2) tick();
    checks++;
    if (tx_count != tx0) begin
      errors++;
      $display("FAIL partial_frame_resp: got %0d responses required 0", tx_count - tx0);
    end
    send_frame(8'h10, 8'h00, 8'h05, 8'h15);
    wait_resp(10);
    apply_with_sync(3);
    wait_resp(10);
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en}
        !== {m_ph[0], m_ph[1], m_ph[2], m_ph[3], 4'h5}) begin
      errors++;
      $display("FAIL mask_commit: ph=%h/%h/%h/%h en=%h required en=5 phase_2=%h",
               phase_1, phase_2, phase_3, phase_4, chan_en, m_ph[1]);
    end
  endtask

  task automatic test_sync_ignored();
    int tx0;
    logic [43:0] snap;
    send_frame(8'h04, 8'h03, 8'hFF, 8'hF8);
    wait_resp(10);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    tick();
    checks++;
    if (phase_4 !== 10'h000) begin
      errors++;
      $display("FAIL sync_in_idle: phase_4=%h required 000", phase_4);
    end
    tx0 = tx_count;
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    repeat (5) tick();
    checks++;
    if ({phase_4, tx_count == tx0} !== {10'h000, 1'b1}) begin
      errors++;
      $display("FAIL sync_in_exec: phase_4=%h responses=%0d required 000/0", phase_4, tx_count - tx0);
    end
    sb.push_back(8'h06);
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    model_commit();
    checks++;
    if (phase_4 !== 10'h3FF) begin
      errors++;
      $display("FAIL late_commit: phase_4=%h required 3ff", phase_4);
    end
    wait_resp(10);
    snap = {phase_1, phase_2, phase_3, phase_4, chan_en};
    apply_with_sync(4);
    wait_resp(10);
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending} !== {snap, 1'b0}) begin
      errors++;
      $display("FAIL apply_no_pending: got %h/%b required %h/0",
               {phase_1, phase_2, phase_3, phase_4, chan_en}, cfg_pending, snap);
    end
  endtask

  task automatic test_sync_timeout();
    send_frame(8'h01, 8'h01, 8'h55, 8'h55);
    wait_resp(10);
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    sb.push_back(8'h15);
    model_commit();
    wait_resp(T + 20);
    checks++;
    if (last_start_cyc - last_rx_cyc != int'(T) + 2) begin
      errors++;
      $display("FAIL sync_timeout_len: got %0d cycles required %0d",
               last_start_cyc - last_rx_cyc, T + 2);
    end
    checks++;
    if ({phase_1, phase_4, cfg_pending} !== {10'h155, m_ph[3], 1'b0}) begin
      errors++;
      $display("FAIL forced_commit: phase_1=%h phase_4=%h pend=%b required 155/%h/0",
               phase_1, phase_4, cfg_pending, m_ph[3]);
    end
  endtask

  task automatic test_busy();
    int  tx0 = tx_count;
    logic data_bad = 1'b0;
    tx_busy = 1'b1;
    send_frame(8'h01, 8'h00, 8'h01, 8'h00);
    repeat (2) tick();
    repeat (98) begin
      if (tx_data !== 8'h06) data_bad = 1'b1;
      tick();
    end
    checks++;
    if ({tx_count == tx0, data_bad} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL busy_hold: starts=%0d data_unstable=%b required 0/0", tx_count - tx0, data_bad);
    end
    tx_busy = 1'b0;
    wait_resp(5);
    repeat (3) tick();
    checks++;
    if ({tx_count - tx0, rx_en} !== {32'sd1, 1'b1}) begin
      errors++;
      $display("FAIL busy_single_pulse: starts=%0d rx_en=%b required 1/1", tx_count - tx0, rx_en);
    end
  endtask

  task automatic test_reset_in_wait();
    int tx0;
    send_frame(8'h02, 8'h00, 8'hAA, 8'hA8);
    wait_resp(10);
    tx0 = tx_count;
    send_frame(8'h20, 8'h00, 8'h00, 8'h20);
    repeat (3) tick();
    RSTn = 1'b0;
    model_reset();
    tick();
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_start, tx_data, rx_en}
        !== {40'h0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_wait: ph=%h/%h/%h/%h en=%h pend=%b txd=%h rxen=%b",
               phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_data, rx_en);
    end
    tick();
    RSTn = 1'b1;
    repeat (3) tick();
    sync_pulse = 1'b1;
    tick();
    sync_pulse = 1'b0;
    repeat (5) tick();
    checks++;
    if ({phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_count == tx0, rx_en}
        !== {m_ph[0], m_ph[1], m_ph[2], m_ph[3], m_mask, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_sync: ph=%h/%h/%h/%h en=%h pend=%b starts=%0d rxen=%b required zeros/f/0/0/1",
               phase_1, phase_2, phase_3, phase_4, chan_en, cfg_pending, tx_count - tx0, rx_en);
    end
  endtask

  initial begin
    RSTn       = 1'b0;
    rx_done    = 1'b0;
    rx_data    = 8'h00;
    sync_pulse = 1'b0;
    tx_busy    = 1'b0;
    test_reset();
    test_phase_write();
    test_commit();
    test_nak();
    test_timeout();
    test_sync_ignored();
    test_sync_timeout();
    test_busy();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
